// File: rtl/snake_position_engine.sv
// snake_position_engine: tracks the snake body on a BOARD_W x BOARD_H tile grid.
// PS/2 make codes steer, frame ticks pace the moves, and grow pulses add a segment.
// Each move is checked against the walls and then against the body, one segment
// per cycle, before the body shifts.
// Build option: define SNAKE_WRAP_EN to make the board toroidal. The head then
// wraps at the edges instead of dying on a wall hit.
module snake_position_engine #(
  parameter int MAX_LEN     = 100,
  parameter int COORD_W     = 32,
  parameter int BOARD_W     = 8,
  parameter int BOARD_H     = 8,
  parameter int MOVE_FRAMES = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [7:0]                 rx_data,
  input  logic                       read_data,
  input  logic                       grow,
  output logic [COORD_W*MAX_LEN-1:0] x_values,
  output logic [COORD_W*MAX_LEN-1:0] y_values,
  output logic [7:0]                 length,
  output logic                       alive
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = $clog2(MOVE_FRAMES + 2);
  localparam logic signed [COORD_W-1:0] BW_S   = COORD_W'(BOARD_W);
  localparam logic signed [COORD_W-1:0] BH_S   = COORD_W'(BOARD_H);
  localparam logic signed [COORD_W-1:0] HOME_X = COORD_W'(BOARD_W / 2);
  localparam logic signed [COORD_W-1:0] HOME_Y = COORD_W'(BOARD_H / 2);
  localparam logic signed [COORD_W-1:0] STEP   = COORD_W'(1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CNT_W-1:0] FRAMES_C  = CNT_W'(MOVE_FRAMES);

  localparam logic [7:0] KEY_W   = 8'h1D;
  localparam logic [7:0] KEY_A   = 8'h1C;
  localparam logic [7:0] KEY_S   = 8'h1B;
  localparam logic [7:0] KEY_D   = 8'h23;
  localparam logic [7:0] KEY_BRK = 8'hF0;
  localparam logic [7:0] KEY_EXT = 8'hE0;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SCAN, S_COMMIT, S_DEAD} state_e;
  // Opposite directions differ only in bit 1, so reversal is a single XOR.
  typedef enum logic [1:0] {DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT} dir_e;

  state_e                     state_q, state_d;
  dir_e                       dir_q, dir_d, pdir_q, pdir_d, key_dir;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc, cnt_sat;
  logic                       grow_q, grow_d, brk_q, brk_d, alive_q, alive_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 len_q, len_d, scan_n, idx_ext;
  logic signed [COORD_W-1:0]  candx_q, candx_d, candy_q, candy_d;
  logic signed [COORD_W-1:0]  xs_q [MAX_LEN];
  logic signed [COORD_W-1:0]  ys_q [MAX_LEN];
  logic signed [COORD_W-1:0]  xs_d [MAX_LEN];
  logic signed [COORD_W-1:0]  ys_d [MAX_LEN];
  logic signed [COORD_W-1:0]  dx, dy, nx, ny;
  logic                       key_hit, key_ok, wall, seg_hit;

  // Decode one PS/2 byte. 0xE0 is transparent; 0xF0 swallows the byte after it.
  always_comb begin
    key_hit = 1'b0;
    key_dir = DIR_RIGHT;
    brk_d   = brk_q;
    if (read_data && (rx_data != KEY_EXT)) begin
      brk_d = (rx_data == KEY_BRK) && !brk_q;
      if (!brk_q) begin
        key_hit = 1'b1;
        case (rx_data)
          KEY_W:   key_dir = DIR_UP;
          KEY_A:   key_dir = DIR_LEFT;
          KEY_S:   key_dir = DIR_DOWN;
          KEY_D:   key_dir = DIR_RIGHT;
          default: key_hit = 1'b0;
        endcase
      end
    end
  end

  // A key that reverses the committed direction is ignored once there is a body behind the head.
  assign key_ok = key_hit &&
                  !((len_q > 8'd1) && (key_dir == dir_e'(dir_q ^ 2'b10)));

  // Candidate head one step along the pending direction, with wall or wrap handling.
  always_comb begin
    dx = '0;
    dy = '0;
    case (pdir_q)
      DIR_UP:   dy = -STEP;
      DIR_DOWN: dy = STEP;
      DIR_LEFT: dx = -STEP;
      default:  dx = STEP;
    endcase
    nx   = xs_q[0] + dx;
    ny   = ys_q[0] + dy;
    wall = nx[COORD_W-1] || (nx >= BW_S) || ny[COORD_W-1] || (ny >= BH_S);
`ifdef SNAKE_WRAP_EN
    if (nx[COORD_W-1])   nx = BW_S - STEP;
    else if (nx >= BW_S) nx = '0;
    if (ny[COORD_W-1])   ny = BH_S - STEP;
    else if (ny >= BH_S) ny = '0;
    wall = 1'b0;
`endif
  end

  // The scan covers the tail only when a grow is pending, because otherwise the tail vacates this move.
  assign scan_n  = grow_q ? len_q : len_q - 8'd1;
  assign idx_ext = 8'(idx_q);
  assign seg_hit = (candx_q == xs_q[idx_q]) && (candy_q == ys_q[idx_q]);
  assign cnt_inc = cnt_q + CNT_W'(frame_tick);
  assign cnt_sat = (cnt_inc > FRAMES_C) ? FRAMES_C : cnt_inc;

  // Next-state logic for the move sequencer and the body arrays.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pdir_d  = pdir_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    candx_d = candx_q;
    candy_d = candy_q;
    len_d   = len_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    if (key_ok) pdir_d = key_dir;
    grow_d = (grow_q && (state_q != S_COMMIT)) || (grow && (len_q < MAX_LEN_B));
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (key_ok) state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_inc >= FRAMES_C) begin
          cnt_d = '0;
          if (wall) begin
            state_d = S_DEAD;
          end else begin
            candx_d = nx;
            candy_d = ny;
            idx_d   = '0;
            state_d = S_SCAN;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SCAN: begin
        cnt_d = cnt_sat;
        if (scan_n == 8'd0)                  state_d = S_COMMIT;
        else if (seg_hit)                    state_d = S_DEAD;
        else if (idx_ext == scan_n - 8'd1)   state_d = S_COMMIT;
        else                                 idx_d = idx_q + IDX_W'(1);
      end
      S_COMMIT: begin
        cnt_d = cnt_sat;
        dir_d = pdir_q;
        if (grow_q && (len_q < MAX_LEN_B)) len_d = len_q + 8'd1;
        xs_d[0] = candx_q;
        ys_d[0] = candy_q;
        for (int i = 1; i < MAX_LEN; i++) begin
          if (8'(i) < len_d) begin
            xs_d[i] = xs_q[i-1];
            ys_d[i] = ys_q[i-1];
          end else begin
            xs_d[i] = '0;
            ys_d[i] = '0;
          end
        end
        state_d = S_RUN;
      end
      S_DEAD: begin
        cnt_d = '0;
        if (key_hit) begin
          state_d = S_IDLE;
          dir_d   = DIR_RIGHT;
          pdir_d  = DIR_RIGHT;
          grow_d  = 1'b0;
          idx_d   = '0;
          len_d   = 8'd1;
          for (int i = 0; i < MAX_LEN; i++) begin
            xs_d[i] = (i == 0) ? HOME_X : '0;
            ys_d[i] = (i == 0) ? HOME_Y : '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    alive_d = (state_d != S_DEAD);
  end

  // State and body registers; reset drops any partially sequenced move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_RIGHT;
      pdir_q  <= DIR_RIGHT;
      cnt_q   <= '0;
      grow_q  <= 1'b0;
      brk_q   <= 1'b0;
      alive_q <= 1'b1;
      idx_q   <= '0;
      len_q   <= 8'd1;
      candx_q <= '0;
      candy_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        xs_q[i] <= (i == 0) ? HOME_X : '0;
        ys_q[i] <= (i == 0) ? HOME_Y : '0;
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pdir_q  <= pdir_d;
      cnt_q   <= cnt_d;
      grow_q  <= grow_d;
      brk_q   <= brk_d;
      alive_q <= alive_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      candx_q <= candx_d;
      candy_q <= candy_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign x_values[COORD_W*g +: COORD_W] = xs_q[g];
    assign y_values[COORD_W*g +: COORD_W] = ys_q[g];
  end

  assign length = len_q;
  assign alive  = alive_q;

endmodule

// File: tb/tb_snake_position_engine.sv
// Self-checking bench for snake_position_engine: directed scenarios with fixed
// expected coordinates, plus a randomized run against a queue-based snake model.
module tb_snake_position_engine;
  localparam int MAX_LEN     = 8;
  localparam int COORD_W     = 32;
  localparam int BOARD_W     = 8;
  localparam int BOARD_H     = 8;
  localparam int MOVE_FRAMES = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic read_data = 1'b0;
  logic grow = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [COORD_W*MAX_LEN-1:0] x_values, y_values;
  logic [7:0] length;
  logic alive;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: body as a queue, head at the front.
  int mq_x[$];
  int mq_y[$];
  int m_dir, m_pdir;          // 0 up, 1 left, 2 down, 3 right
  bit m_alive, m_idle, m_grow, m_brk;
  int DX[4] = '{0, -1, 0, 1};
  int DY[4] = '{-1, 0, 1, 0};

  snake_position_engine #(
    .MAX_LEN(MAX_LEN), .COORD_W(COORD_W), .BOARD_W(BOARD_W),
    .BOARD_H(BOARD_H), .MOVE_FRAMES(MOVE_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .rx_data(rx_data),
    .read_data(read_data), .grow(grow), .x_values(x_values),
    .y_values(y_values), .length(length), .alive(alive)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sx(int i);
    return $signed(x_values[COORD_W*i +: COORD_W]);
  endfunction

  function automatic int sy(int i);
    return $signed(y_values[COORD_W*i +: COORD_W]);
  endfunction

  function automatic void model_reset();
    mq_x = {4};
    mq_y = {4};
    m_dir = 3; m_pdir = 3;
    m_alive = 1; m_idle = 1; m_grow = 0; m_brk = 0;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    int d;
    if (b == 8'hE0) return;
    if (m_brk) begin m_brk = 0; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    case (b)
      8'h1D: d = 0;
      8'h1C: d = 1;
      8'h1B: d = 2;
      8'h23: d = 3;
      default: d = -1;
    endcase
    if (d < 0) return;
    if (!m_alive) begin model_reset(); return; end
    if (mq_x.size() > 1 && d == (m_dir + 2) % 4) return;
    m_pdir = d;
    m_idle = 0;
  endfunction

  function automatic void model_move();
    int cx, cy, n;
    cx = mq_x[0] + DX[m_pdir];
    cy = mq_y[0] + DY[m_pdir];
`ifdef SNAKE_WRAP_EN
    cx = (cx + BOARD_W) % BOARD_W;
    cy = (cy + BOARD_H) % BOARD_H;
`else
    if (cx < 0 || cx >= BOARD_W || cy < 0 || cy >= BOARD_H) begin
      m_alive = 0;
      return;
    end
`endif
    n = m_grow ? mq_x.size() : mq_x.size() - 1;
    for (int i = 0; i < n; i++)
      if (mq_x[i] == cx && mq_y[i] == cy) begin m_alive = 0; return; end
    mq_x.push_front(cx);
    mq_y.push_front(cy);
    if (m_grow) m_grow = 0;
    else begin void'(mq_x.pop_back()); void'(mq_y.pop_back()); end
    m_dir = m_pdir;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; read_data = 1'b0; grow = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0;
    model_byte(b);
  endtask

  task automatic pulse_grow();
    @(negedge clk);
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
    if (mq_x.size() < MAX_LEN) m_grow = 1;
  endtask

  task automatic send_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  task automatic do_move();
    send_ticks(MOVE_FRAMES);
    repeat (MAX_LEN + 8) @(negedge clk);
    if (m_alive && !m_idle) model_move();
  endtask

  // Length-5 snake heading right: (6,5),(5,5),(4,5),(3,5),(2,5).
  task automatic build_len5();
    do_reset();
    send_byte(8'h1C); do_move(); do_move();
    send_byte(8'h1B); do_move();
    send_byte(8'h23);
    for (int k = 0; k < 4; k++) begin pulse_grow(); do_move(); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (length !== 8'd1) begin n_fail++; $display("FAIL reset_length: got %0d want 1", length); end
    n_checks++;
    if (alive !== 1'b1) begin n_fail++; $display("FAIL reset_alive: got %0b want 1", alive); end
    n_checks++;
    if (sx(0) != 4 || sy(0) != 4) begin n_fail++; $display("FAIL reset_head: got (%0d,%0d) want (4,4)", sx(0), sy(0)); end
    for (int i = 1; i < MAX_LEN; i++) begin
      n_checks++;
      if (sx(i) != 0 || sy(i) != 0) begin n_fail++; $display("FAIL reset_slot%0d: got (%0d,%0d) want (0,0)", i, sx(i), sy(i)); end
    end
    send_ticks(MOVE_FRAMES);
    repeat (4) @(negedge clk);
    n_checks++;
    if (sx(0) != 4 || sy(0) != 4) begin n_fail++; $display("FAIL idle_no_move: got (%0d,%0d) want (4,4)", sx(0), sy(0)); end
  endtask

  task automatic test_first_move();
    do_reset();
    send_byte(8'h23);
    do_move();
    n_checks++;
    if (sx(0) != 5 || sy(0) != 4 || length !== 8'd1 || alive !== 1'b1) begin
      n_fail++; $display("FAIL first_move: got (%0d,%0d) len %0d alive %0b want (5,4) len 1 alive 1", sx(0), sy(0), length, alive);
    end
  endtask

  task automatic test_break_codes();
    do_reset();
    send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h1C);
    do_move();
    n_checks++;
    if (sx(0) != 5 || sy(0) != 4) begin n_fail++; $display("FAIL break_ignored: got (%0d,%0d) want (5,4)", sx(0), sy(0)); end
    send_byte(8'hE0); send_byte(8'h1B);
    do_move();
    n_checks++;
    if (sx(0) != 5 || sy(0) != 5) begin n_fail++; $display("FAIL ext_prefix: got (%0d,%0d) want (5,5)", sx(0), sy(0)); end
  endtask

  task automatic test_grow_and_reverse();
    do_reset();
    send_byte(8'h23);
    pulse_grow();
    do_move();
    n_checks++;
    if (length !== 8'd2 || sx(0) != 5 || sy(0) != 4 || sx(1) != 4 || sy(1) != 4) begin
      n_fail++; $display("FAIL grow: len %0d s0 (%0d,%0d) s1 (%0d,%0d) want len 2 s0 (5,4) s1 (4,4)", length, sx(0), sy(0), sx(1), sy(1));
    end
    send_byte(8'h1C);
    do_move();
    n_checks++;
    if (length !== 8'd2 || sx(0) != 6 || sy(0) != 4 || sx(1) != 5 || sx(2) != 0) begin
      n_fail++; $display("FAIL reverse_ignored: len %0d s0 (%0d,%0d) s1x %0d s2x %0d want len 2 s0 (6,4) s1x 5 s2x 0", length, sx(0), sy(0), sx(1), sx(2));
    end
  endtask

  task automatic test_wall();
    do_reset();
    send_byte(8'h23);
    do_move(); do_move(); do_move();
    n_checks++;
    if (sx(0) != 7 || sy(0) != 4) begin n_fail++; $display("FAIL wall_approach: got (%0d,%0d) want (7,4)", sx(0), sy(0)); end
    do_move();
    n_checks++;
`ifdef SNAKE_WRAP_EN
    if (alive !== 1'b1 || sx(0) != 0 || sy(0) != 4) begin
      n_fail++; $display("FAIL wall_wrap: alive %0b head (%0d,%0d) want alive 1 (0,4)", alive, sx(0), sy(0));
    end
`else
    if (alive !== 1'b0 || sx(0) != 7 || sy(0) != 4) begin
      n_fail++; $display("FAIL wall_hit: alive %0b head (%0d,%0d) want alive 0 (7,4)", alive, sx(0), sy(0));
    end
`endif
  endtask

  task automatic test_self_collision();
    build_len5();
    send_byte(8'h1D); do_move();
    send_byte(8'h1C); do_move();
    send_byte(8'h1B); do_move();
    n_checks++;
    if (alive !== 1'b0 || length !== 8'd5 || sx(0) != 5 || sy(0) != 4) begin
      n_fail++; $display("FAIL self_hit: alive %0b len %0d head (%0d,%0d) want alive 0 len 5 (5,4)", alive, length, sx(0), sy(0));
    end
    send_byte(8'h1D);
    @(negedge clk);
    n_checks++;
    if (alive !== 1'b1 || length !== 8'd1 || sx(0) != 4 || sy(0) != 4 || sx(1) != 0 || sy(1) != 0) begin
      n_fail++; $display("FAIL dead_restart: alive %0b len %0d head (%0d,%0d) s1 (%0d,%0d) want alive 1 len 1 (4,4) (0,0)", alive, length, sx(0), sy(0), sx(1), sy(1));
    end
  endtask

  task automatic test_reset_in_scan();
    build_len5();
    send_ticks(MOVE_FRAMES);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (length !== 8'd1 || alive !== 1'b1 || sx(0) != 4 || sy(0) != 4 || sx(1) != 0 || sy(4) != 0) begin
      n_fail++; $display("FAIL reset_scan_async: len %0d alive %0b head (%0d,%0d) s1x %0d s4y %0d want len 1 alive 1 (4,4) 0 0", length, alive, sx(0), sy(0), sx(1), sy(4));
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    send_ticks(MOVE_FRAMES);
    repeat (MAX_LEN + 8) @(negedge clk);
    n_checks++;
    if (length !== 8'd1 || sx(0) != 4 || sy(0) != 4 || sx(2) != 0) begin
      n_fail++; $display("FAIL reset_scan_idle: len %0d head (%0d,%0d) s2x %0d want len 1 (4,4) 0", length, sx(0), sy(0), sx(2));
    end
  endtask

  task automatic test_saturation();
    do_reset();
    send_byte(8'h23);
    pulse_grow(); do_move(); pulse_grow(); do_move();
    send_byte(8'h1B);
    pulse_grow(); do_move(); pulse_grow(); do_move();
    send_byte(8'h1C);
    pulse_grow(); do_move(); pulse_grow(); do_move(); pulse_grow(); do_move();
    n_checks++;
    if (length !== 8'd8) begin n_fail++; $display("FAIL sat_fill: len %0d want 8", length); end
    pulse_grow(); do_move();
    n_checks++;
    if (length !== 8'd8 || sx(0) != 2 || sy(0) != 6 || sx(7) != 5 || sy(7) != 4) begin
      n_fail++; $display("FAIL sat_hold: len %0d head (%0d,%0d) tail (%0d,%0d) want len 8 (2,6) (5,4)", length, sx(0), sy(0), sx(7), sy(7));
    end
  endtask

  task automatic test_random();
    logic [7:0] codes[7] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hE0, 8'h23};
    int r, ex, ey;
    do_reset();
    for (int it = 0; it < 220; it++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        r = $urandom_range(0, 7);
        if (r == 7) send_byte(8'($urandom_range(0, 255)));
        else        send_byte(codes[r]);
      end else if (r < 50) begin
        pulse_grow();
      end else begin
        do_move();
        n_checks++;
        if (length !== 8'(mq_x.size()) || alive !== m_alive) begin
          n_fail++; $display("FAIL rand_state it%0d: len %0d alive %0b want len %0d alive %0b", it, length, alive, mq_x.size(), m_alive);
        end
        for (int i = 0; i < MAX_LEN; i++) begin
          ex = (i < mq_x.size()) ? mq_x[i] : 0;
          ey = (i < mq_y.size()) ? mq_y[i] : 0;
          n_checks++;
          if (sx(i) != ex || sy(i) != ey) begin
            n_fail++; $display("FAIL rand_slot it%0d s%0d: got (%0d,%0d) want (%0d,%0d)", it, i, sx(i), sy(i), ex, ey);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_break_codes();
    test_grow_and_reverse();
    test_wall();
    test_self_collision();
    test_reset_in_scan();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_position_engine.md
SNAKE_POSITION_ENGINE -- requirements
Module: snake_position_engine

Interface
REQ-001 SHALL have parameter MAX_LEN, default 100: number of segment slots in the packed coordinate outputs.
REQ-002 SHALL have parameter COORD_W, default 32: width of one packed coordinate.
REQ-003 SHALL have parameters BOARD_W and BOARD_H, default 8 each: board size in tiles.
REQ-004 SHALL have parameter MOVE_FRAMES, default 15: number of frame ticks between moves.
REQ-005 SHALL have port clk, input, 1 bit: 100 MHz system clock, the only clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per frame (VGA screenEnd, already synchronised to clk).
REQ-008 SHALL have ports rx_data (input, 8 bits) and read_data (input, 1 bit): PS/2 byte, valid for one cycle while read_data=1.
REQ-009 SHALL have port grow, input, 1 bit: pulse requesting one extra segment.
REQ-010 SHALL have ports x_values and y_values, output, COORD_W*MAX_LEN bits each: segment i at bits [COORD_W*i +: COORD_W]; slot 0 is the head, in tile units.
REQ-011 SHALL have ports length (output, 8 bits, valid segment count) and alive (output, 1 bit).

Function
REQ-012 SHALL implement states IDLE, RUN, SCAN, COMMIT, DEAD.
REQ-013 SHALL decode PS/2 set-2 make codes W=0x1D (up), A=0x1C (left), S=0x1B (down), D=0x23 (right); all other codes ignored.
REQ-014 SHALL discard the byte following 0xF0 (break prefix); 0xE0 SHALL be ignored without affecting the next byte.
REQ-015 SHALL ignore a key that reverses the committed direction (e.g. left while moving right) when length>1.
REQ-016 SHALL make a valid direction key in IDLE set pending_dir and enter RUN; in DEAD, a valid key SHALL reinitialise to reset values and enter IDLE.
REQ-017 In RUN, SHALL count frame_tick; on the MOVE_FRAMES-th tick, SHALL clear the counter, latch the candidate head (head + pending_dir) and enter SCAN in the next cycle.
REQ-018 SHALL treat a candidate with x<0, x>=BOARD_W, y<0 or y>=BOARD_H as a wall hit, go to DEAD, and leave the arrays unchanged.
REQ-019 In SCAN, SHALL compare the candidate with one segment per cycle, for indices 0..n-1, where n=length if a grow is pending else length-1; any match SHALL go to DEAD.
REQ-020 SCAN with n=0 SHALL last exactly one cycle, then proceed to COMMIT.
REQ-021 COMMIT SHALL last one cycle: slot i <= slot i-1 for i=1..MAX_LEN-1, slot 0 <= candidate, committed dir <= pending_dir; if grow is pending, length SHALL increment and the pending flag SHALL clear; then return to RUN.
REQ-022 SHALL latch grow pulses into a single pending flag, serviced at the next COMMIT; when length=MAX_LEN, grow SHALL be dropped and length saturates.
REQ-023 Slots at index >= length SHALL read 0 after every COMMIT.
REQ-024 A frame_tick arriving during SCAN or COMMIT SHALL still be counted; keys arriving in any state SHALL update pending_dir subject to REQ-015.
REQ-025 alive SHALL be 0 only in DEAD; outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 On reset=0, asynchronously: state=IDLE, length=1, slot 0=(BOARD_W/2, BOARD_H/2)=(4,4), other slots 0, dir=pending_dir=right, counter=0, grow pending=0, break flag=0, alive=1.
REQ-027 Reset asserted mid-SCAN or mid-COMMIT SHALL abort the operation without writing any partial shift.

Configuration
REQ-028 With SNAKE_WRAP_EN defined, an out-of-range candidate SHALL wrap modulo BOARD_W/BOARD_H (e.g. x=-1 -> BOARD_W-1) and be self-checked normally; without it, REQ-018 applies.

Verification
REQ-029 Reset, press 0x23, 15 frame_ticks -> head (5,4), length=1, alive=1.
REQ-030 From (4,4) facing right, send 0xF0,0x1C -> no direction change; after next move head=(5,4).
REQ-031 Grow pulse then one move from (4,4) right -> length=2, slot0=(5,4), slot1=(4,4).
REQ-032 Head at (7,4) moving right, next move -> alive=0, head remains (7,4); with SNAKE_WRAP_EN -> head=(0,4), alive=1.
REQ-033 Length-5 snake steered into its own body (U-turn via up,left,down) -> alive=0 at the end of SCAN; a key press then returns to IDLE with reset values.
REQ-034 Assert reset during SCAN -> all outputs equal the REQ-026 values on the next cycle.
